// File: rtl/avl_mem_if.sv
// Avalon-MM 64-bit burst bus between an initiator (master) and a memory responder (slave).
// Signals: ready/burstbegin/addr/size/read_req/write_req/wdata/be/rdata_valid/rdata.
interface avl_mem_if;
  logic        avl_ready;
  logic        avl_burstbegin;
  logic [23:0] avl_addr;
  logic [6:0]  avl_size;
  logic        avl_read_req;
  logic        avl_write_req;
  logic [63:0] avl_wdata;
  logic [7:0]  avl_be;
  logic        avl_rdata_valid;
  logic [63:0] avl_rdata;

  modport master (
    input  avl_ready,
    input  avl_rdata_valid,
    input  avl_rdata,
    output avl_burstbegin,
    output avl_addr,
    output avl_size,
    output avl_read_req,
    output avl_write_req,
    output avl_wdata,
    output avl_be
  );

  modport slave (
    output avl_ready,
    output avl_rdata_valid,
    output avl_rdata,
    input  avl_burstbegin,
    input  avl_addr,
    input  avl_size,
    input  avl_read_req,
    input  avl_write_req,
    input  avl_wdata,
    input  avl_be
  );
endinterface

// File: rtl/avl_mem_responder.sv
// Block-RAM backed Avalon-MM burst responder with fixed read latency and stall injection.
// Ports: clk, reset_n (sync, active-low), avl (avl_mem_if.slave: handshake, bursts, read return).
module avl_mem_responder #(
  parameter int DEPTH_LOG2   = 12,
  parameter int READ_LATENCY = 4,
  parameter int STALL_EVERY  = 0
) (
  input logic      clk,
  input logic      reset_n,
  avl_mem_if.slave avl
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam bit STALL_EN = STALL_EVERY > 1;
  localparam int SE = STALL_EN ? STALL_EVERY : 2;
  localparam int CW = $clog2(SE);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WBURST = 2'd1;
  localparam logic [1:0] S_RISSUE = 2'd2;

  typedef logic [DEPTH_LOG2-1:0] addr_t;

  logic [63:0] mem_q [DEPTH];

  logic [1:0]    state_q, state_d;
  addr_t         addr_q, addr_d;
  logic [6:0]    rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;

  logic       acc;
  logic       issue;
  logic       we;
  addr_t      wa;
  addr_t      req_addr;
  logic [6:0] size_eff;

  logic [READ_LATENCY-1:0] pv_q;
  logic [63:0]             pd_q [READ_LATENCY];

  // A beat seen on the reset edge is never taken.
  assign acc = reset_n & ready_q
             & (avl.avl_read_req | avl.avl_write_req);
  assign issue = reset_n & (state_q == S_RISSUE);
  assign req_addr = addr_t'(avl.avl_addr);
  assign size_eff = (avl.avl_size == 7'd0)
                  ? 7'd1 : avl.avl_size;
  assign cnt_d = (cnt_q == CW'(SE - 1))
               ? '0 : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    we      = 1'b0;
    wa      = addr_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (acc && avl.avl_write_req) begin
          we = 1'b1;
          wa = req_addr;
          if (size_eff > 7'd1) begin
            addr_d  = req_addr + 1'b1;
            rem_d   = size_eff - 7'd1;
            state_d = S_WBURST;
          end
        end else if (acc) begin
          addr_d  = req_addr;
          rem_d   = size_eff;
          state_d = S_RISSUE;
        end
      end
      (state_q == S_WBURST): begin
        if (acc && avl.avl_write_req) begin
          we     = 1'b1;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 7'd1;
          if (rem_q == 7'd1) state_d = S_IDLE;
        end
      end
      (state_q == S_RISSUE): begin
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 7'd1;
        if (rem_q == 7'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is computed for the coming cycle from the next state and count.
  assign ready_d = (state_d != S_RISSUE)
                 && !(STALL_EN && cnt_d == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (avl.avl_be[b]) begin
          mem_q[wa][8*b +: 8] <= avl.avl_wdata[8*b +: 8];
        end
      end
    end
  end

  // Stages only load on a valid beat, so the last stage holds between beats.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pv_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pd_q[k] <= '0;
      end
    end else begin
      pv_q[0] <= issue;
      if (issue) pd_q[0] <= mem_q[addr_q];
      for (int k = 1; k < READ_LATENCY; k++) begin
        pv_q[k] <= pv_q[k-1];
        if (pv_q[k-1]) pd_q[k] <= pd_q[k-1];
      end
    end
  end

  assign avl.avl_ready       = ready_q;
  assign avl.avl_rdata_valid = pv_q[READ_LATENCY-1];
  assign avl.avl_rdata       = pd_q[READ_LATENCY-1];
endmodule

// File: tb/tb_avl_mem_responder.sv
// Randomized bench for avl_mem_responder against a cycle-level reference model.
// Covers latency, byte enables, wrap, read bursts, stall injection and mid-read reset.
module tb_avl_mem_responder;
  localparam int DL    = 7;
  localparam int LAT   = 4;
  localparam int SE    = 3;
  localparam int DEPTH = 1 << DL;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  avl_mem_if avl();

  avl_mem_responder #(
    .DEPTH_LOG2  (DL),
    .READ_LATENCY(LAT),
    .STALL_EVERY (SE)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .avl    (avl)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(
    input logic [63:0] o,
    input logic [63:0] d,
    input logic [7:0]  be);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++)
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Reference model: memory array, burst bookkeeping and a
  // schedule of expected read beats keyed by edge number.
  logic [63:0] m_mem [DEPTH];
  logic [63:0] sched [int];
  int          e;
  int          busy_until;
  int          wb_rem;
  int          wb_addr;
  int          m_sz;
  int          m_a;
  logic        m_rdy;
  logic        m_rdv;
  logic [63:0] m_rdata;

  always @(posedge clk) begin
    if (!reset_n) begin
      e = 0;
      m_rdy = 1'b0;
      m_rdv = 1'b0;
      m_rdata = '0;
      busy_until = -1;
      wb_rem = 0;
      sched.delete();
    end else begin
      e++;
      if (m_rdy &&
          (avl.avl_read_req || avl.avl_write_req)) begin
        m_sz = (avl.avl_size == 7'd0)
             ? 1 : int'(avl.avl_size);
        m_a = int'(avl.avl_addr) % DEPTH;
        if (wb_rem > 0) begin
          if (avl.avl_write_req) begin
            m_mem[wb_addr] = merge(m_mem[wb_addr],
              avl.avl_wdata, avl.avl_be);
            wb_addr = (wb_addr + 1) % DEPTH;
            wb_rem--;
          end
        end else if (avl.avl_write_req) begin
          m_mem[m_a] = merge(m_mem[m_a],
            avl.avl_wdata, avl.avl_be);
          wb_addr = (m_a + 1) % DEPTH;
          wb_rem = m_sz - 1;
        end else begin
          for (int i = 0; i < m_sz; i++)
            sched[e + LAT + i] = m_mem[(m_a + i) % DEPTH];
          busy_until = e + m_sz - 1;
        end
      end
      if (sched.exists(e)) begin
        m_rdv = 1'b1;
        m_rdata = sched[e];
        sched.delete(e);
      end else begin
        m_rdv = 1'b0;
      end
      m_rdy = (e % SE != 0) && (e > busy_until);
    end
    #1;
    chk("ready", 64'(avl.avl_ready), 64'(m_rdy));
    chk("rdata_valid", 64'(avl.avl_rdata_valid),
        64'(m_rdv));
    chk("rdata", avl.avl_rdata, m_rdata);
  end

  logic [63:0] wbuf [128];
  logic [7:0]  bebuf [128];

  task automatic idle();
    avl.avl_read_req   = 1'b0;
    avl.avl_write_req  = 1'b0;
    avl.avl_burstbegin = 1'b0;
    avl.avl_addr       = 24'($urandom);
    avl.avl_size       = 7'($urandom);
    avl.avl_wdata      = {$urandom, $urandom};
    avl.avl_be         = 8'($urandom);
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    while (avl.avl_ready !== 1'b1) begin
      if (n == 100) begin
        chk("ready_timeout", 64'(avl.avl_ready), 64'd1);
        return;
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drive(input logic rd, input logic wr,
                       input logic bb,
                       input logic [23:0] a,
                       input logic [6:0] sz,
                       input logic [63:0] d,
                       input logic [7:0] be);
    avl.avl_read_req   = rd;
    avl.avl_write_req  = wr;
    avl.avl_burstbegin = bb;
    avl.avl_addr       = a;
    avl.avl_size       = sz;
    avl.avl_wdata      = d;
    avl.avl_be         = be;
    wait_rdy();
    @(posedge clk);
    #1;
  endtask

  // junk: random read_req, ignored addr/size and gaps mid-burst
  task automatic wr_burst(input logic [23:0] a,
                          input logic [6:0] sz,
                          input bit junk);
    int n;
    n = (sz == 7'd0) ? 1 : int'(sz);
    for (int i = 0; i < n; i++) begin
      drive(junk ? 1'($urandom) : 1'b0, 1'b1, i == 0,
            i == 0 ? a : 24'($urandom),
            i == 0 ? sz : 7'($urandom),
            wbuf[i], bebuf[i]);
      if (junk && i < n - 1 && $urandom_range(3) == 0) begin
        avl.avl_write_req = 1'b0;
        avl.avl_read_req  = 1'($urandom);
        @(posedge clk);
        #1;
      end
    end
    idle();
  endtask

  task automatic rd_burst(input logic [23:0] a,
                          input logic [6:0] sz);
    drive(1'b1, 1'b0, 1'b1, a, sz,
          {$urandom, $urandom}, 8'($urandom));
    idle();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int blk = 0; blk < DEPTH / 64; blk++) begin
      for (int i = 0; i < 64; i++) begin
        wbuf[i] = {$urandom, $urandom};
        bebuf[i] = 8'hFF;
      end
      wr_burst(24'(blk * 64), 7'd64, 1'b0);
    end

    wbuf[0] = 64'h0123456789ABCDEF;
    bebuf[0] = 8'hFF;
    wr_burst(24'h10, 7'd1, 1'b0);
    rd_burst(24'h10, 7'd1);

    wbuf[0] = '1;
    wr_burst(24'h20, 7'd1, 1'b0);
    wbuf[0] = '0;
    bebuf[0] = 8'h0F;
    wr_burst(24'h20, 7'd1, 1'b0);
    rd_burst(24'h20, 7'd1);

    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 64'(i + 1);
      bebuf[i] = 8'hFF;
    end
    wr_burst(24'(DEPTH - 2), 7'd4, 1'b0);
    rd_burst(24'(DEPTH - 2), 7'd4);
    rd_burst(24'h0, 7'd2);

    rd_burst(24'h40, 7'd8);

    for (int i = 0; i < 6; i++) begin
      wbuf[i] = {$urandom, $urandom};
      bebuf[i] = 8'hFF;
    end
    wr_burst(24'h50, 7'd6, 1'b0);
    rd_burst(24'h50, 7'd6);

    rd_burst(24'h30, 7'd8);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd_burst(24'h30, 7'd8);

    for (int t = 0; t < 300; t++) begin
      logic [6:0] sz;
      sz = ($urandom_range(15) == 0)
         ? 7'($urandom) : 7'($urandom_range(12));
      if ($urandom_range(1) == 0) begin
        for (int i = 0; i < 128; i++) begin
          wbuf[i] = {$urandom, $urandom};
          bebuf[i] = 8'($urandom);
        end
        wr_burst(24'($urandom), sz, 1'b1);
      end else begin
        rd_burst(24'($urandom), sz);
      end
      if ($urandom_range(3) == 0)
        repeat ($urandom_range(3)) @(posedge clk);
      #0;
    end

    repeat (LAT + 20) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d",
             n_chk, n_err);
    $fatal(1, "watchdog");
  end
endmodule
